// File: rtl/battle_turn_ctrl.sv
// Battleship game-flow controller: placement, alternating player/PC turns,
// life checks, per-turn player timeout, extra shot on hit, draw limit and restart.
module battle_turn_ctrl #(
    parameter int TURN_TIMEOUT = 50000000,
    parameter int TIMER_W      = 26,
    parameter int MAX_ROUNDS   = 50,
    parameter int ROUND_W      = 8,
    parameter int FIRST_PLAYER = 0,
    parameter int EXTRA_SHOT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               end_move_barcos,
    input  logic               end_move_pc_barcos,
    input  logic               end_attack,
    input  logic               attack_hit,
    input  logic               end_pc_attack,
    input  logic               pc_hit,
    input  logic               dead_pc,
    input  logic               dead_player,
    output logic               en_put_barcos,
    output logic               en_attack,
    output logic               en_check_pc_life,
    output logic               en_pc_attack,
    output logic               en_check_player_life,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               timeout_pulse,
    output logic [TIMER_W-1:0] timer_left,
    output logic [ROUND_W-1:0] round_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLACE     = 3'd1,
        P_ATTACK  = 3'd2,
        P_CHECK   = 3'd3,
        PC_ATTACK = 3'd4,
        PC_CHECK  = 3'd5,
        OVER      = 3'd6
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TURN_TIMEOUT);
    localparam logic [ROUND_W-1:0] ROUND_MAX  = ROUND_W'(MAX_ROUNDS);

    state_t             state_q, state_d;
    logic               placeP_q, placeP_d;
    logic               placePc_q, placePc_d;
    logic               hit_q, hit_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [1:0]         winner_q, winner_d;
    logic               pulse_q, pulse_d;
    logic [ROUND_W-1:0] roundInc;

    assign roundInc = (round_q == {ROUND_W{1'b1}}) ? round_q : round_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            placeP_q  <= 1'b0;
            placePc_q <= 1'b0;
            hit_q     <= 1'b0;
            timer_q   <= '0;
            round_q   <= '0;
            winner_q  <= 2'b00;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            placeP_q  <= placeP_d;
            placePc_q <= placePc_d;
            hit_q     <= hit_d;
            timer_q   <= timer_d;
            round_q   <= round_d;
            winner_q  <= winner_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        placeP_d  = placeP_q;
        placePc_d = placePc_q;
        hit_d     = hit_q;
        timer_d   = timer_q;
        round_d   = round_q;
        winner_d  = winner_q;
        pulse_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = PLACE;
            end
            PLACE: begin
                placeP_d  = placeP_q | end_move_barcos;
                placePc_d = placePc_q | end_move_pc_barcos;
                if (placeP_d && placePc_d) begin
                    placeP_d  = 1'b0;
                    placePc_d = 1'b0;
                    if (FIRST_PLAYER == 0) begin
                        state_d = P_ATTACK;
                        timer_d = TIMER_LOAD;
                    end else begin
                        state_d = PC_ATTACK;
                    end
                end
            end
            P_ATTACK: begin
                if (timer_q != '0) timer_d = timer_q - 1'b1;
                if (end_attack) begin
                    state_d = P_CHECK;
                    hit_d   = attack_hit;
                end else if (TURN_TIMEOUT != 0 && timer_q == TIMER_W'(1)) begin
                    state_d = PC_ATTACK;
                    pulse_d = 1'b1;
                    if (FIRST_PLAYER != 0) begin
                        round_d = roundInc;
                        if (MAX_ROUNDS != 0 && roundInc == ROUND_MAX) begin
                            state_d  = OVER;
                            winner_d = 2'b11;
                        end
                    end
                end
            end
            P_CHECK: begin
                if (dead_pc) begin
                    state_d  = OVER;
                    winner_d = 2'b01;
                end else if (EXTRA_SHOT != 0 && hit_q) begin
                    state_d = P_ATTACK;
                    timer_d = TIMER_LOAD;
                end else begin
                    state_d = PC_ATTACK;
                    if (FIRST_PLAYER != 0) begin
                        round_d = roundInc;
                        if (MAX_ROUNDS != 0 && roundInc == ROUND_MAX) begin
                            state_d  = OVER;
                            winner_d = 2'b11;
                        end
                    end
                end
            end
            PC_ATTACK: begin
                if (end_pc_attack) begin
                    state_d = PC_CHECK;
                    hit_d   = pc_hit;
                end
            end
            PC_CHECK: begin
                if (dead_player) begin
                    state_d  = OVER;
                    winner_d = 2'b10;
                end else if (EXTRA_SHOT != 0 && hit_q) begin
                    state_d = PC_ATTACK;
                end else begin
                    state_d = P_ATTACK;
                    timer_d = TIMER_LOAD;
                    if (FIRST_PLAYER == 0) begin
                        round_d = roundInc;
                        // A draw ends the game instead of starting the next player turn.
                        if (MAX_ROUNDS != 0 && roundInc == ROUND_MAX) begin
                            state_d  = OVER;
                            winner_d = 2'b11;
                            timer_d  = timer_q;
                        end
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_d   = IDLE;
                    round_d   = '0;
                    winner_d  = 2'b00;
                    placeP_d  = 1'b0;
                    placePc_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign en_put_barcos        = (state_q == PLACE);
    assign en_attack            = (state_q == P_ATTACK);
    assign en_check_pc_life     = (state_q == P_CHECK);
    assign en_pc_attack         = (state_q == PC_ATTACK);
    assign en_check_player_life = (state_q == PC_CHECK);
    assign game_over            = (state_q == OVER);
    assign winner               = winner_q;
    assign timeout_pulse        = pulse_q;
    assign timer_left           = timer_q;
    assign round_count          = round_q;

endmodule

// File: doc/battle_turn_ctrl.md
Name: battle_turn_ctrl

Overview:
Parametrised game-flow controller for the Battleship top level. It sequences ship placement, alternating player/PC attack turns and life checks, and ends the game on a kill or a round limit. Compared with the first-generation controller, it adds:
- an internal per-turn timeout counter, replacing the external timeout input;
- placement-done latching;
- an optional extra shot after a hit;
- a selectable first mover;
- a draw limit;
- restart from game over.

Parameters:
TURN_TIMEOUT, 50000000, cycles allowed for a player attack turn; 0 disables the timeout.
TIMER_W, 26, width of the turn timer; must satisfy 2^TIMER_W > TURN_TIMEOUT.
MAX_ROUNDS, 50, completed rounds before a draw is declared; 0 disables the limit.
ROUND_W, 8, width of the round counter; must satisfy 2^ROUND_W > MAX_ROUNDS.
FIRST_PLAYER, 0, side that attacks first: 0 = player, 1 = PC.
EXTRA_SHOT, 1, 1 = a hit grants the same side another attack.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  begin the game from IDLE; restart from OVER
end_move_barcos  in  1  player ship placement done (pulse or level)
end_move_pc_barcos  in  1  PC ship placement done (pulse or level)
end_attack  in  1  player attack resolved
attack_hit  in  1  player shot hit; sampled only with end_attack
end_pc_attack  in  1  PC attack resolved
pc_hit  in  1  PC shot hit; sampled only with end_pc_attack
dead_pc  in  1  PC has no ships left; sampled only in P_CHECK
dead_player  in  1  player has no ships left; sampled only in PC_CHECK
en_put_barcos  out  1  high in PLACE
en_attack  out  1  high in P_ATTACK
en_check_pc_life  out  1  high in P_CHECK
en_pc_attack  out  1  high in PC_ATTACK
en_check_player_life  out  1  high in PC_CHECK
game_over  out  1  high in OVER
winner  out  2  00 = none, 01 = player, 10 = PC, 11 = draw
timeout_pulse  out  1  one-cycle pulse when a player turn is forfeited
timer_left  out  TIMER_W  remaining cycles in the current player turn
round_count  out  ROUND_W  completed rounds

Behaviour:
- Reset: reset low at a rising clk edge forces the following registered values:
  - state = IDLE; placement latches cleared; hit latch cleared;
  - timer_left = 0, round_count = 0, winner = 00, timeout_pulse = 0.
  - All enable outputs and game_over are decoded from state, so they are 0 in IDLE.
  - Reset overrides every other input and applies in any state, including mid-turn.
- States: IDLE, PLACE, P_ATTACK, P_CHECK, PC_ATTACK, PC_CHECK, OVER. The enables are pure state decodes and take effect in the cycle after the transition edge.
- IDLE: start = 1 moves to PLACE. Otherwise hold.
- PLACE:
  - Each done input sets its own sticky latch.
  - When both latches are set, including set in this same cycle, move to the first attack state: P_ATTACK if FIRST_PLAYER = 0, else PC_ATTACK.
  - The done inputs need not arrive together.
  - Latches clear on leaving PLACE.
- Entering P_ATTACK from any state loads timer_left = TURN_TIMEOUT.
- P_ATTACK:
  - timer_left decrements by 1 each cycle while it is nonzero.
  - end_attack = 1: go to P_CHECK and latch hit = attack_hit.
  - Else, if TURN_TIMEOUT != 0 and timer_left == 1: the turn is forfeited. Go to PC_ATTACK and assert timeout_pulse for exactly the next cycle.
  - end_attack in the same cycle as expiry takes priority, and no timeout pulse is produced.
  - timer_left holds 0 after forfeit. It holds its value in all non-player states.
- P_CHECK (one cycle):
  - dead_pc: go to OVER, winner = 01.
  - Else if EXTRA_SHOT and hit: go back to P_ATTACK (timer reloads).
  - Else go to PC_ATTACK.
- PC_ATTACK: end_pc_attack = 1 goes to PC_CHECK and latches hit = pc_hit. There is no timeout on the PC side.
- PC_CHECK (one cycle):
  - dead_player: go to OVER, winner = 10.
  - Else if EXTRA_SHOT and hit: go back to PC_ATTACK.
  - Else go to P_ATTACK.
- Round counting:
  - A round completes when control passes from the second mover back to the first mover, either through a CHECK state or through a player timeout.
  - FIRST_PLAYER = 0: the rounds end on PC_CHECK to P_ATTACK.
  - FIRST_PLAYER = 1: the rounds end on P_CHECK to PC_ATTACK, or on a P_ATTACK timeout.
  - Extra-shot loops do not count as round completions.
  - round_count increments on that edge, saturating at the maximum value.
  - If MAX_ROUNDS != 0 and the incremented value equals MAX_ROUNDS, go to OVER with winner = 11 instead of continuing.
  - A kill detected in the same CHECK cycle outranks the draw.
- OVER:
  - game_over = 1; winner holds.
  - start = 1 goes to IDLE and clears round_count, winner and the latches.
  - All other inputs are ignored.
- Unreachable encodings go to IDLE on the next edge.

Test Plan:
- Parameters TURN_TIMEOUT=4, MAX_ROUNDS=3, FIRST_PLAYER=0, EXTRA_SHOT=1. Release reset, pulse start → PLACE next cycle. Pulse end_move_barcos, then end_move_pc_barcos 3 cycles later → P_ATTACK one cycle after the second pulse, timer_left=4.
- In P_ATTACK, no end_attack → timer_left counts 4,3,2,1. On the edge where timer_left was 1: state becomes PC_ATTACK, timeout_pulse=1 for one cycle, round_count stays 0.
- end_attack with attack_hit=1, dead_pc=0 → P_CHECK, then P_ATTACK again with timer reloaded to 4. Then end_attack with attack_hit=0 → P_CHECK, then PC_ATTACK.
- end_attack raised in the same cycle that timer_left=1 → P_CHECK, and timeout_pulse stays 0.
- Three full rounds with no hits and no deaths → round_count reaches 3 on the third PC_CHECK exit. Then OVER, winner=11, game_over=1. Pulse start → IDLE, round_count=0, winner=00.
- dead_player=1 in PC_CHECK → OVER, winner=10. Drive reset low during P_ATTACK with timer_left=2 → IDLE on the next edge, all outputs 0.
